ltc_frame_assembler: RTL and testbench
======================================

LTC_FRAME_ASSEMBLER -- requirements
Module: ltc_frame_assembler

Interface
REQ-001 SHALL have parameter BIT_PERIOD, default 16, nominal LTC bit cell length in clk cycles (even, 8..1024).
REQ-002 SHALL have parameter LOCK_FRAMES, default 2, number of consecutive sync words needed to assert locked.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ltc_in  input  1  raw biphase-mark LTC stream, asynchronous to clk.
REQ-006 SHALL have port timecode  output  80  last complete frame; bit n = nth received bit (bit 0 first received).
REQ-007 SHALL have port timecode_valid  output  1  one-cycle pulse when timecode is updated.
REQ-008 SHALL have port locked  output  1  high while frame alignment is established.
REQ-009 SHALL have port bit_error  output  1  one-cycle pulse on an illegal edge interval.
REQ-010 SHALL have port frame_error  output  1  one-cycle pulse when a locked frame ends without sync.

Function
REQ-011 SHALL pass ltc_in through a 2-flop synchronizer; an edge is a difference between synchronizer output and its one-cycle-delayed copy.
REQ-012 SHALL count clk cycles since the last edge in an interval counter, saturating at 2*BIT_PERIOD; the counter resets to 1 on the cycle after an edge.
REQ-013 SHALL classify each edge's interval I: I < BIT_PERIOD/4 -> glitch; BIT_PERIOD/4 <= I < 3*BIT_PERIOD/4 -> short; 3*BIT_PERIOD/4 <= I <= 5*BIT_PERIOD/4 -> long; I > 5*BIT_PERIOD/4 -> glitch.
REQ-014 SHALL decode bits: long with no pending half -> bit 0; first short -> set half_pending; second short -> bit 1 and clear half_pending.
REQ-015 SHALL treat long with half_pending set, or any glitch, as an error: pulse bit_error, clear half_pending, emit no bit.
REQ-016 SHALL shift each decoded bit into bit 79 of an 80-bit shift register, shifting existing contents toward bit 0.
REQ-017 SHALL detect sync when shift register bits [79:64] equal 16'hBFFC on the cycle after a bit is shifted in.
REQ-018 SHALL, on sync detect, load timecode with the shift register and pulse timecode_valid exactly 2 clk cycles after the completing edge leaves the synchronizer.
REQ-019 SHALL implement states IDLE, HUNT, LOCKED; reset -> IDLE; IDLE -> HUNT on any classified (non-glitch) edge.
REQ-020 SHALL maintain a 7-bit bit counter, cleared on sync detect, incremented per decoded bit.
REQ-021 SHALL in HUNT count consecutive sync detects spaced exactly 80 bits apart; reaching LOCK_FRAMES -> LOCKED; a sync at any other spacing restarts the count at 1.
REQ-022 SHALL in LOCKED, if the bit counter reaches 80 without sync, pulse frame_error, go to HUNT, and zero the sync count.
REQ-023 SHALL, if sync detect and bit counter reaching 80 occur on the same cycle, treat it as sync (no frame_error).
REQ-024 SHALL, when the interval counter saturates (no edge for 2*BIT_PERIOD), go to IDLE, clear half_pending, bit counter and sync count; timecode retains its value.
REQ-025 SHALL emit timecode_valid on every sync detect in HUNT and LOCKED, independent of locked.
REQ-026 SHALL drive locked high iff state is LOCKED, registered.
REQ-027 SHALL not emit bit_error in IDLE (first edge after IDLE only starts timing).

Reset
REQ-028 SHALL, while rst is low, asynchronously force: timecode 0, timecode_valid 0, locked 0, bit_error 0, frame_error 0, state IDLE, all counters, shift register and synchronizer 0.
REQ-029 SHALL, on reset asserted mid-frame, discard partial frame; after release, require a fresh LOCK_FRAMES syncs to lock.

Verification
REQ-030 Clean stream, BIT_PERIOD 16, three frames with bits 0..63 = 64'h0123_4567_89AB_CDEF -> timecode_valid on each frame end, timecode[63:0] matches, timecode[79:64]=16'hBFFC, locked high after second sync.
REQ-031 Interval 2 cycles inserted (glitch) -> bit_error pulse, no bit shifted; interval 24 cycles -> bit_error pulse.
REQ-032 Locked, one sync bit flipped (bit 66 = 0) -> frame_error pulse after 80th bit, locked low, no timecode_valid for that frame.
REQ-033 Locked, ltc_in held constant 32 cycles -> state IDLE, locked low, timecode unchanged, no error pulses.
REQ-034 Short, long sequence (phase error) -> bit_error pulse, half_pending cleared, next clean short-short decodes as 1.
REQ-035 rst low for 1 cycle mid-frame while locked -> all outputs 0 immediately; re-lock only after 2 further syncs.

Source files
------------

// File: rtl/ltc_frame_assembler.sv
// ltc_frame_assembler
//   Recovers 80-bit SMPTE LTC frames from a raw biphase-mark stream.
//   The stream is synchronised and its edge intervals are timed. Each
//   interval is classed as short, long or glitch and decoded into bits,
//   which are shifted into an 80-bit frame register. A frame is aligned by
//   the 16-bit sync word 16'hBFFC.
//
// Parameters
//   BIT_PERIOD  nominal bit cell length in clk cycles (even, 8..1024)
//   LOCK_FRAMES consecutive 80-bit-spaced sync words needed to lock
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous, active-low reset
//   ltc_in         raw LTC line, asynchronous to clk
//   timecode       last complete frame, bit 0 = first received bit
//   timecode_valid one-cycle pulse when timecode is reloaded
//   locked         high while frame alignment is established
//   bit_error      one-cycle pulse on an illegal edge interval
//   frame_error    one-cycle pulse when a locked frame ends without sync
module ltc_frame_assembler #(
  parameter int BIT_PERIOD  = 16,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ltc_in,
  output logic [79:0] timecode,
  output logic        timecode_valid,
  output logic        locked,
  output logic        bit_error,
  output logic        frame_error
);

  localparam int CW  = $clog2(2 * BIT_PERIOD + 1);
  localparam int SCW = $clog2(LOCK_FRAMES + 1);

  localparam logic [CW-1:0]  SAT    = CW'(2 * BIT_PERIOD);
  localparam logic [CW-1:0]  SAT_M1 = CW'(2 * BIT_PERIOD - 1);
  localparam logic [CW-1:0]  Q1     = CW'(BIT_PERIOD / 4);
  localparam logic [CW-1:0]  Q3     = CW'(3 * BIT_PERIOD / 4);
  localparam logic [CW-1:0]  Q5     = CW'(5 * BIT_PERIOD / 4);
  localparam logic [SCW-1:0] LOCK_N = SCW'(LOCK_FRAMES);
  localparam logic [SCW-1:0] ONE_SC = SCW'(1);

  typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      sync_reg;          // [0],[1] synchroniser, [2] delayed copy
  logic [CW-1:0]   int_cnt_reg;
  logic            half_pending_reg, half_pending_next;
  logic [79:0]     sr_reg;
  logic            shifted_reg;
  logic [6:0]      bit_cnt_reg;
  logic [SCW-1:0]  sync_cnt_reg, sync_cnt_next, sync_cnt_inc;
  logic            tv_next, fe_next;
  logic [79:0]     timecode_reg;
  logic            timecode_valid_reg, locked_reg, bit_error_reg, frame_error_reg;

  logic edge_det, is_short, is_long, is_glitch, timeout;
  logic bit_emit, decode_err, sync_det, frame_end;

  assign edge_det  = sync_reg[1] ^ sync_reg[2];
  assign is_short  = edge_det && (int_cnt_reg >= Q1) && (int_cnt_reg < Q3);
  assign is_long   = edge_det && (int_cnt_reg >= Q3) && (int_cnt_reg <= Q5);
  assign is_glitch = edge_det && !is_short && !is_long;
  // Fires once, on the cycle the interval counter would reach saturation.
  assign timeout   = !edge_det && (int_cnt_reg == SAT_M1);

  // A short only completes a '1' when it is the second half of a cell.
  assign bit_emit   = (is_short && half_pending_reg) || (is_long && !half_pending_reg);
  assign decode_err = is_glitch || (is_long && half_pending_reg);

  assign sync_det  = shifted_reg && (sr_reg[79:64] == 16'hBFFC);
  assign frame_end = shifted_reg && (bit_cnt_reg == 7'd80);

  always_comb begin
    half_pending_next = half_pending_reg;
    if (timeout || is_glitch || is_long)
      half_pending_next = 1'b0;
    else if (is_short)
      half_pending_next = !half_pending_reg;
  end

  // Count restarts at 1 unless this sync is exactly one frame after the last.
  assign sync_cnt_inc = ((bit_cnt_reg == 7'd80) && (sync_cnt_reg != '0)) ?
                        sync_cnt_reg + 1'b1 : ONE_SC;

  always_comb begin
    state_next    = state_reg;
    sync_cnt_next = sync_cnt_reg;
    tv_next       = 1'b0;
    fe_next       = 1'b0;
    if (timeout) begin
      state_next    = IDLE;
      sync_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (is_short || is_long)
            state_next = HUNT;
        end
        HUNT: begin
          if (sync_det) begin
            tv_next       = 1'b1;
            sync_cnt_next = sync_cnt_inc;
            if (sync_cnt_inc >= LOCK_N)
              state_next = LOCKED;
          end
        end
        LOCKED: begin
          // Sync wins over a simultaneous 80th bit.
          if (sync_det) begin
            tv_next = 1'b1;
          end else if (frame_end) begin
            fe_next       = 1'b1;
            state_next    = HUNT;
            sync_cnt_next = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg           <= '0;
      int_cnt_reg        <= '0;
      half_pending_reg   <= 1'b0;
      sr_reg             <= '0;
      shifted_reg        <= 1'b0;
      bit_cnt_reg        <= '0;
      sync_cnt_reg       <= '0;
      state_reg          <= IDLE;
      timecode_reg       <= '0;
      timecode_valid_reg <= 1'b0;
      locked_reg         <= 1'b0;
      bit_error_reg      <= 1'b0;
      frame_error_reg    <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[1:0], ltc_in};

      if (edge_det)
        int_cnt_reg <= CW'(1);
      else if (int_cnt_reg < SAT)
        int_cnt_reg <= int_cnt_reg + 1'b1;

      half_pending_reg <= half_pending_next;

      if (bit_emit)
        sr_reg <= {is_short, sr_reg[79:1]};
      shifted_reg <= bit_emit;

      // Saturates so a long unsynchronised run can never alias to 80.
      if (timeout)
        bit_cnt_reg <= '0;
      else if (sync_det)
        bit_cnt_reg <= bit_emit ? 7'd1 : 7'd0;
      else if (bit_emit && bit_cnt_reg != 7'd127)
        bit_cnt_reg <= bit_cnt_reg + 7'd1;

      sync_cnt_reg <= sync_cnt_next;
      state_reg    <= state_next;

      if (tv_next)
        timecode_reg <= sr_reg;
      timecode_valid_reg <= tv_next;
      locked_reg         <= (state_next == LOCKED);
      // The first edge after IDLE only starts interval timing.
      bit_error_reg      <= decode_err && (state_reg != IDLE);
      frame_error_reg    <= fe_next;
    end
  end

  assign timecode       = timecode_reg;
  assign timecode_valid = timecode_valid_reg;
  assign locked         = locked_reg;
  assign bit_error      = bit_error_reg;
  assign frame_error    = frame_error_reg;

endmodule

// File: tb/tb_ltc_frame_assembler.sv
// Testbench for ltc_frame_assembler: biphase-mark frame generator with a
// scoreboard of expected timecodes checked whenever timecode_valid pulses.
module tb_ltc_frame_assembler;

  localparam int BP = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ltc_in = 1'b0;
  logic [79:0] timecode;
  logic        timecode_valid, locked, bit_error, frame_error;

  always #5 clk = ~clk;

  ltc_frame_assembler #(.BIT_PERIOD(BP), .LOCK_FRAMES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .ltc_in         (ltc_in),
    .timecode       (timecode),
    .timecode_valid (timecode_valid),
    .locked         (locked),
    .bit_error      (bit_error),
    .frame_error    (frame_error)
  );

  int          errors = 0;
  int          checks = 0;
  int          be_cnt = 0;
  int          fe_cnt = 0;
  int          frame_no = 0;
  logic [79:0] exp_q[$];
  logic [79:0] mon_exp;

  localparam logic [63:0] DATA_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DATA_B = 64'hFEDC_BA98_7654_3210;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_toggle();
    ltc_in = ~ltc_in;
  endtask

  task automatic tx_bit(input logic b);
    tx_toggle();
    if (b) begin
      wait_cyc(BP / 2);
      tx_toggle();
      wait_cyc(BP / 2);
    end else begin
      wait_cyc(BP);
    end
  endtask

  // Sends the first nbits of f; a '0' cell at index gbit carries two 2-cycle glitch edges.
  task automatic tx_frame(input logic [79:0] f, input int gbit, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (i == gbit) begin
        tx_toggle(); wait_cyc(2);
        tx_toggle(); wait_cyc(2);
        tx_toggle(); wait_cyc(BP - 4);
      end else begin
        tx_bit(f[i]);
      end
    end
  endtask

  // Scoreboard consumer and error-pulse counters.
  always @(negedge clk) begin
    if (rst) begin
      if (bit_error)   be_cnt++;
      if (frame_error) fe_cnt++;
      if (timecode_valid) begin
        frame_no++;
        if (exp_q.size() == 0) begin
          check("valid_unexpected", {79'd0, timecode_valid}, 80'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("timecode", timecode, mon_exp);
          $display("frame %0d: timecode=%h locked=%0b", frame_no, timecode, locked);
        end
      end
    end
  end

  logic [79:0] fr_good, fr_bad, fr_alt;

  initial begin
    fr_good = {16'hBFFC, DATA_A};
    fr_bad  = {16'hBFF8, DATA_A};     // bit 66 cleared
    fr_alt  = {16'hBFFC, DATA_B};

    // Reset state
    wait_cyc(3);
    check("rst_timecode", timecode, 80'd0);
    check("rst_valid", {79'd0, timecode_valid}, 80'd0);
    check("rst_locked", {79'd0, locked}, 80'd0);
    check("rst_bit_error", {79'd0, bit_error}, 80'd0);
    check("rst_frame_error", {79'd0, frame_error}, 80'd0);
    rst = 1'b1;
    wait_cyc(40);

    // Clean stream: lock after the second sync
    repeat (4) tx_bit(1'b0);
    exp_q.push_back(fr_good); tx_frame(fr_good, -1, 80);
    exp_q.push_back(fr_good); tx_frame(fr_good, -1, 80);
    check("locked_one_sync", {79'd0, locked}, 80'd0);
    exp_q.push_back(fr_good); tx_frame(fr_good, -1, 80);
    check("locked_two_sync", {79'd0, locked}, 80'd1);
    check("clean_bit_errors", be_cnt, 0);

    // Corrupted sync while locked
    tx_frame(fr_bad, -1, 80);
    exp_q.push_back(fr_alt); tx_frame(fr_alt, -1, 80);
    check("frame_error_count", fe_cnt, 1);
    check("unlock_on_frame_error", {79'd0, locked}, 80'd0);
    exp_q.push_back(fr_alt); tx_frame(fr_alt, -1, 80);
    check("rehunt_one_sync", {79'd0, locked}, 80'd0);
    tx_toggle(); wait_cyc(5);
    check("rehunt_locked", {79'd0, locked}, 80'd1);

    // Line held constant: drop to IDLE, timecode kept, no errors
    wait_cyc(45);
    check("timeout_unlocked", {79'd0, locked}, 80'd0);
    check("timeout_timecode", timecode, fr_alt);
    check("timeout_bit_errors", be_cnt, 0);
    check("timeout_frame_errors", fe_cnt, 1);

    // Over-long interval, phase error, then a frame with glitches
    tx_bit(1'b0); tx_bit(1'b0);
    tx_toggle(); wait_cyc(24);
    tx_toggle(); wait_cyc(4);
    check("long_interval_error", be_cnt, 1);
    wait_cyc(4);
    tx_toggle(); wait_cyc(16);
    exp_q.push_back(fr_good); tx_frame(fr_good, 4, 80);
    check("phase_and_glitch_errors", be_cnt, 4);
    exp_q.push_back(fr_good); tx_frame(fr_good, -1, 80);
    check("glitch_frame_one_sync", {79'd0, locked}, 80'd0);
    tx_frame(fr_alt, -1, 30);
    check("glitch_frame_locked", {79'd0, locked}, 80'd1);

    // Reset mid-frame while locked
    rst = 1'b0;
    #1;
    check("mid_rst_timecode", timecode, 80'd0);
    check("mid_rst_locked", {79'd0, locked}, 80'd0);
    check("mid_rst_valid", {79'd0, timecode_valid}, 80'd0);
    check("mid_rst_bit_error", {79'd0, bit_error}, 80'd0);
    check("mid_rst_frame_error", {79'd0, frame_error}, 80'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(40);
    repeat (2) tx_bit(1'b0);
    exp_q.push_back(fr_alt); tx_frame(fr_alt, -1, 80);
    exp_q.push_back(fr_alt); tx_frame(fr_alt, -1, 80);
    check("post_rst_one_sync", {79'd0, locked}, 80'd0);
    tx_toggle(); wait_cyc(5);
    check("post_rst_locked", {79'd0, locked}, 80'd1);
    wait_cyc(10);

    check("final_bit_errors", be_cnt, 4);
    check("final_frame_errors", fe_cnt, 1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
